bayes_weight_sampler: RTL and testbench

Multi-lane sequential weight sampler for the Bayesian in-memory computing core. It accepts one packed set of base weights and per-bit confidence masks, then emits a programmable number of stochastic weight samples through a valid/ready stream. Each lane has its own LFSR that supplies the random mask. It sits between the weight store and the MAC array and replaces the single-word combinational perturbation stage.

---
 rtl/bayes_weight_sampler_pkg.sv | 20 ++
 rtl/bayes_weight_sampler_if.sv | 33 +++
 rtl/bayes_weight_sampler_lfsr.sv | 29 ++
 rtl/bayes_weight_sampler.sv | 107 ++++++++++
 tb/tb_bayes_weight_sampler.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/bayes_weight_sampler_pkg.sv
// bayes_pkg: shared types and constants for the Bayesian weight sampler.
//   sampler_state_e  - sampler FSM states
//   DEF_TAPS         - default Galois feedback polynomial
//   DEF_SEED         - default base seed (lane k uses DEF_SEED + k)
//   lane_slice_lsb() - LSB index of lane k inside a packed lane vector
package bayes_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SAMPLE = 1'b1
    } sampler_state_e;

    localparam logic [15:0] DEF_TAPS = 16'hB400;
    localparam logic [15:0] DEF_SEED = 16'hACE1;

    function automatic int lane_slice_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/bayes_weight_sampler_if.sv
// bayes_weight_sampler_if: weight-set input stream and sample output stream.
//   in_valid/in_ready     - weight set handshake
//   base_weight           - packed base weights, lane k at [k*WORD_SIZE +: WORD_SIZE]
//   confidence            - packed per-bit confidence, 1 = trusted bit
//   num_samples           - samples to draw for this set (0 treated as 1)
//   out_valid/out_ready   - sample handshake
//   out_weight, out_last  - perturbed sample and end-of-set flag
// master: weight store / consumer side; slave: the sampler.
interface bayes_weight_sampler_if #(
    parameter int WORD_SIZE = 8,
    parameter int LANES     = 4,
    parameter int CNT_W     = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [LANES*WORD_SIZE-1:0] base_weight;
    logic [LANES*WORD_SIZE-1:0] confidence;
    logic [CNT_W-1:0]           num_samples;
    logic                       out_valid;
    logic                       out_ready;
    logic [LANES*WORD_SIZE-1:0] out_weight;
    logic                       out_last;

    modport master (
        output in_valid, base_weight, confidence, num_samples, out_ready,
        input  in_ready, out_valid, out_weight, out_last
    );

    modport slave (
        input  in_valid, base_weight, confidence, num_samples, out_ready,
        output in_ready, out_valid, out_weight, out_last
    );
endinterface

// File: rtl/bayes_weight_sampler_lfsr.sv
// sampler_lfsr: per-lane Galois LFSR.
//   clk, rst_n - clock, synchronous active-low reset (loads SEED)
//   step       - advance one Galois step
//   state      - current LFSR contents
// An all-zero state can never leave zero on its own, so a step from zero
// reloads the seed instead.
module sampler_lfsr
    import bayes_pkg::*;
#(
    parameter int               LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS  = DEF_TAPS,
    parameter logic [LFSR_W-1:0] SEED  = DEF_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (step) begin
            if (state == '0)
                state <= SEED;
            else
                state <= (state >> 1) ^ (state[0] ? TAPS : '0);
        end
    end
endmodule

// File: rtl/bayes_weight_sampler.sv
// bayes_weight_sampler: multi-lane sequential stochastic weight sampler.
// Captures one weight set and emits num_samples perturbed samples; each
// untrusted bit flips when its lane's LFSR mask bit is 0.
//   clk, rst_n  - clock, synchronous active-low reset
//   bus         - bayes_weight_sampler_if.slave (input set + sample stream)
//   flip_count  - saturating count of flipped bits over all handshakes,
//                 present only when BAYES_SAMPLER_STATS_EN is defined
// LFSRs advance only on an output handshake, so the sample sequence does
// not depend on consumer stalls.
module bayes_weight_sampler
    import bayes_pkg::*;
#(
    parameter int                WORD_SIZE = 8,
    parameter int                LANES     = 4,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = DEF_TAPS,
    parameter logic [LFSR_W-1:0] SEED      = DEF_SEED,
    parameter int                CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    bayes_weight_sampler_if.slave   bus
`ifdef BAYES_SAMPLER_STATS_EN
    ,
    output logic [31:0]             flip_count
`endif
);
    localparam int W = LANES * WORD_SIZE;

    sampler_state_e                 state;
    logic [W-1:0]                   base_q;
    logic [W-1:0]                   conf_q;
    logic [CNT_W-1:0]               remaining;
    logic [LANES-1:0][LFSR_W-1:0]   lfsr;
    logic [W-1:0]                   mask;
    logic [W-1:0]                   flips;
    logic                           step;
    logic                           unused_lfsr_bits;

    assign step = (state == SAMPLE) && bus.out_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sampler_lfsr #(
            .LFSR_W (LFSR_W),
            .TAPS   (TAPS),
            .SEED   (SEED + LFSR_W'(k))
        ) u_lfsr (
            .clk   (clk),
            .rst_n (rst_n),
            .step  (step),
            .state (lfsr[k])
        );
        assign mask[lane_slice_lsb(k, WORD_SIZE) +: WORD_SIZE] = lfsr[k][WORD_SIZE-1:0];
    end

    // Upper LFSR bits only feed the recurrence, never the mask.
    assign unused_lfsr_bits = ^lfsr;

    assign flips          = ~conf_q & ~mask;
    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == SAMPLE);
    assign bus.out_last   = (state == SAMPLE) && (remaining == CNT_W'(1));
    // Forced to zero outside SAMPLE so idle/reset outputs are clean.
    assign bus.out_weight = (state == SAMPLE) ? (base_q ^ flips) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_q    <= '0;
            conf_q    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        base_q    <= bus.base_weight;
                        conf_q    <= bus.confidence;
                        remaining <= (bus.num_samples == '0) ? CNT_W'(1) : bus.num_samples;
                        state     <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (bus.out_ready) begin
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef BAYES_SAMPLER_STATS_EN
    logic [32:0] flip_sum;

    assign flip_sum = {1'b0, flip_count} + 33'($countones(flips));

    always_ff @(posedge clk) begin
        if (!rst_n)
            flip_count <= '0;
        else if (step)
            flip_count <= flip_sum[32] ? 32'hFFFF_FFFF : flip_sum[31:0];
    end
`endif

endmodule

// File: tb/tb_bayes_weight_sampler.sv
// tb_bayes_weight_sampler: scoreboard bench for bayes_weight_sampler.
// Stimulus pushes expected samples into a queue when a set is issued; a
// monitor pops and compares on every output handshake. Hand-computed
// constants cover the post-reset masks; a small Galois model tracks the
// LFSRs across the longer scenarios.
module tb_bayes_weight_sampler;
    localparam int WS = 8;
    localparam int LN = 4;
    localparam int CW = 8;
    localparam int W  = WS * LN;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bayes_weight_sampler_if #(.WORD_SIZE(WS), .LANES(LN), .CNT_W(CW)) bus ();

`ifdef BAYES_SAMPLER_STATS_EN
    logic [31:0] flip_count;
`endif

    bayes_weight_sampler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef BAYES_SAMPLER_STATS_EN
        ,
        .flip_count (flip_count)
`endif
    );

    typedef struct packed {
        logic [W-1:0] w;
        logic         last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] m_lfsr [LN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < LN; k++) m_lfsr[k] = 16'hACE1 + 16'(k);
    endtask

    task automatic model_step();
        for (int k = 0; k < LN; k++) begin
            if (m_lfsr[k] == 16'h0)
                m_lfsr[k] = 16'hACE1 + 16'(k);
            else
                m_lfsr[k] = (m_lfsr[k] >> 1) ^ (m_lfsr[k][0] ? 16'hB400 : 16'h0);
        end
    endtask

    function automatic logic [W-1:0] model_sample(input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        logic [7:0]   mk;
        r = '0;
        for (int k = 0; k < LN; k++) begin
            mk = m_lfsr[k][7:0];
            r[k*WS +: WS] = b[k*WS +: WS] ^ (~c[k*WS +: WS] & ~mk);
        end
        return r;
    endfunction

    // Monitor: compare each handshaken sample against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %h expected none", bus.out_weight);
                end else begin
                    e = exp_q.pop_front();
                    check("sample_weight", bus.out_weight, e.w);
                    check("sample_last", 32'(bus.out_last), 32'(e.last));
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] b, input logic [W-1:0] c, input logic [CW-1:0] n);
        int   cnt;
        int   t;
        exp_t e;
        cnt = (n == 0) ? 1 : int'(n);
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
        end
        bus.in_valid    = 1'b1;
        bus.base_weight = b;
        bus.confidence  = c;
        bus.num_samples = n;
        for (int i = 0; i < cnt; i++) begin
            e.w    = model_sample(b, c);
            e.last = (i == cnt - 1);
            exp_q.push_back(e);
            model_step();
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("latency_out_valid", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((!bus.in_ready || exp_q.size() != 0) && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        if (!bus.in_ready || exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
        end
    endtask

    initial begin
        logic [W-1:0] w0;

        bus.in_valid    = 1'b0;
        bus.base_weight = '0;
        bus.confidence  = '0;
        bus.num_samples = '0;
        bus.out_ready   = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_weight", bus.out_weight, 32'h0);
`ifdef BAYES_SAMPLER_STATS_EN
        check("rst_flip_count", flip_count, 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Zero confidence, first sample after reset: masks E1..E4 inverted
        bus.out_ready = 1'b1;
        send(32'h0, 32'h0, 8'd1);
        check("zc_weight_const", bus.out_weight, 32'h1B1C1D1E);
        check("zc_last_const", 32'(bus.out_last), 32'd1);
        @(posedge clk); #1;
        check("zc_in_ready_next", 32'(bus.in_ready), 32'd1);
        check("zc_out_valid_next", 32'(bus.out_valid), 32'd0);
`ifdef BAYES_SAMPLER_STATS_EN
        check("zc_flip_count", flip_count, 32'd15);
`endif

        // Full confidence: three copies of the base, last only on the third
        send(32'h5A5A5A5A, 32'hFFFFFFFF, 8'd3);
        wait_idle();

        // Stall: output must hold while out_ready is low
        bus.out_ready = 1'b0;
        send(32'h00FF3C00, 32'h0F00F0AA, 8'd2);
        w0 = bus.out_weight;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_weight_hold", bus.out_weight, w0);
            check("stall_last_hold", 32'(bus.out_last), 32'd0);
        end
        bus.out_ready = 1'b1;
        wait_idle();

        // num_samples = 0 -> exactly one sample
        send(32'h12345678, 32'hF0F0F0F0, 8'd0);
        check("n0_last", 32'(bus.out_last), 32'd1);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        check("n0_no_extra", 32'(bus.out_valid), 32'd0);

        // Reset mid-SAMPLE after four handshakes
        send(32'h0, 32'h0, 8'd10);
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_weight", bus.out_weight, 32'h0);
        exp_q.delete();
        model_reset();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        send(32'h0, 32'h0, 8'd1);
        check("midrst_reseed_const", bus.out_weight, 32'h1B1C1D1E);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
